ifetch: RTL and testbench
=========================

# ifetch

Instruction-fetch unit that sits directly upstream of the 1024-word instruction ROM. It owns the program counter and drives the ROM word address. It pairs the ROM's registered instruction word with the PC that produced it and presents both to decode under a valid/stall handshake. It also handles branch/jump redirects, detects illegal fetch addresses, and keeps a fetch counter.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first byte address fetched after reset.
- `ADDR_W`, default 10: ROM word-address width; legal PCs are below 4·2^ADDR_W.

Ports:
- `clk`, in, 1: sole clock; all state updates on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `stall`, in, 1: decode cannot accept; hold the current output.
- `redirect`, in, 1: single-cycle pulse; next fetch comes from `redirect_pc`.
- `redirect_pc`, in, 32: byte target address for the redirect.
- `imem_addr`, out, ADDR_W: word address to the ROM; combinational from next-PC select.
- `imem_ir`, in, 32: ROM output, registered inside the ROM; one-cycle read latency.
- `if_instr`, out, 32: equals `imem_ir`.
- `if_pc`, out, 32: byte PC of `if_instr`.
- `if_pc4`, out, 32: `if_pc + 4`, modulo 2^32.
- `if_valid`, out, 1: `if_instr`/`if_pc` are meaningful.
- `fault`, out, 1: sticky illegal-fetch flag.
- `fault_pc`, out, 32: offending address captured on fault.
- `fetch_count`, out, 32: number of accepted instructions.

## Operation
- State register `pc_f` holds the PC of the word currently on `imem_ir`. FSM states are BOOT, RUN and FAULT.
- Next-PC select (`nxt`), in priority order:
  - reset or BOOT → `RESET_PC`;
  - `redirect` → `redirect_pc`;
  - `stall` → `pc_f`, re-reading the same word so `imem_ir` stays stable;
  - otherwise → `pc_f + 4`.
- `imem_addr = nxt[ADDR_W+1:2]`.
- In FAULT, `imem_addr` holds `pc_f[ADDR_W+1:2]`.
- Legality check: `nxt[1:0] == 0` and `nxt[31:ADDR_W+2] == 0`. It is evaluated only in RUN.
- An illegal `nxt` in RUN causes, at the clock edge:
  - state ← FAULT;
  - `fault_pc` ← `nxt`;
  - `pc_f` unchanged.
- Legal `nxt` in BOOT/RUN: `pc_f` ← `nxt`.
- Transitions:
  - BOOT → RUN unconditionally after one cycle.
  - RUN → FAULT on an illegal `nxt`.
  - FAULT is left only by reset.
- `if_valid = (state == RUN)`.
- Acceptance: an instruction is accepted when `if_valid & ~stall & ~redirect`.
- With `redirect` asserted, the current output is treated as wrong-path; decode drops it. Fetch adds no bubble.
- `fetch_count` increments on each acceptance and saturates at 32'hFFFF_FFFF.
- Redirect and stall in the same cycle: redirect wins, and the target is fetched.

## Timing
- Reset values: `pc_f = RESET_PC`, state BOOT, `if_valid = 0`, `fault = 0`, `fault_pc = 0`, `fetch_count = 0`.
- While `rst_n = 0`, `imem_addr = RESET_PC` word index.
- Boot sequence:
  - Edge E0 is the first edge sampled with `rst_n = 1`; at E0 the state moves to RUN.
  - In the cycle after E0, `if_valid = 1` with `if_pc = RESET_PC`.
- Fetch latency: `nxt` chosen in cycle N appears on `if_instr`/`if_pc` in cycle N+1.
- Redirect: pulse in cycle N → the target instruction is valid in cycle N+1.
- Stall: outputs are bit-identical for every stalled cycle. Throughput resumes at one instruction per cycle the cycle after `stall` drops.
- Wrap: a sequential step from the last ROM word (`4·2^ADDR_W − 4`) is illegal and causes FAULT.
- Reset mid-operation, including during FAULT: returns to BOOT at that edge. All counters and flags clear.

## Structure
- Shared package `mips_pkg` holds:
  - the FSM state enum (BOOT, RUN, FAULT);
  - the `RESET_PC` default;
  - the `ADDR_W` default;
  - the constant 32'd4.
- Single flat module; no sub-module needed.
- The saturating counter may be split out as `sat_counter` if it is reused elsewhere.

## Test plan
- Reset with ROM word0 = 32'h2008_0005 and word1 = 32'h2009_0001:
  - cycle after E0 → `if_valid = 1`, `if_pc = 0`, `if_instr = 32'h2008_0005`;
  - next cycle → `if_pc = 4`, word1.
- `stall` held 3 cycles at `if_pc = 8` → `if_pc`, `if_instr` and `fetch_count` unchanged; after release, `if_pc = 12` in the next cycle.
- `redirect = 1`, `redirect_pc = 32'h40`, concurrent with `stall = 1` → next cycle `if_pc = 32'h40` and `if_instr` = word 16; `fetch_count` not incremented that cycle.
- `redirect_pc = 32'h42` (misaligned) → next cycle `fault = 1`, `fault_pc = 32'h42`, `if_valid = 0`, held until `rst_n = 0`.
- Sequential run to `if_pc = 32'hFFC` → next cycle `fault = 1`, `fault_pc = 32'h1000`.
- Pulse `rst_n = 0` for one cycle while in FAULT at `fetch_count = 7` → `fault = 0` and `fetch_count = 0`; the cycle after the first `rst_n = 1` edge has `if_pc = RESET_PC` and `if_valid = 1`.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end.
//   fetch_state_e     : instruction-fetch FSM states (BOOT, RUN, FAULT)
//   RESET_PC_DEFAULT  : default first byte address fetched after reset
//   ADDR_W_DEFAULT    : default instruction ROM word-address width
//   PC_STEP           : byte distance between sequential instructions
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          ADDR_W_DEFAULT   = 10;
   localparam logic [31:0] PC_STEP          = 32'd4;

endpackage : mips_pkg

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Instruction-fetch unit in front of a registered instruction ROM. Owns the
// program counter, drives the ROM word address, pairs the ROM output with the
// PC that produced it, handles redirects and stalls, flags illegal fetch
// addresses and counts accepted instructions.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   stall        in   decode cannot accept; hold the current output
//   redirect     in   one-cycle pulse; next fetch comes from redirect_pc
//   redirect_pc  in   byte target address of the redirect
//   imem_addr    out  ROM word address (combinational from next-PC select)
//   imem_ir      in   ROM word, one cycle after imem_addr
//   if_instr     out  instruction to decode (equals imem_ir)
//   if_pc        out  byte PC of if_instr
//   if_pc4       out  if_pc + 4
//   if_valid     out  if_instr/if_pc are meaningful
//   fault        out  sticky illegal-fetch flag
//   fault_pc     out  address that caused the fault
//   fetch_count  out  saturating count of accepted instructions
// -----------------------------------------------------------------------------
module ifetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_ir,
   output logic [31:0]       if_instr,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_pc4,
   output logic              if_valid,
   output logic              fault,
   output logic [31:0]       fault_pc,
   output logic [31:0]       fetch_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_f_q, pc_f_d;
   logic [31:0]  fault_pc_q, fault_pc_d;
   logic [31:0]  fetch_count_q, fetch_count_d;

   logic [31:0]  nxt;
   logic         nxt_legal;
   logic         accept;

   // Next-PC select. Reset and BOOT force the reset vector so the ROM is
   // already reading the first word when the FSM enters RUN. A stall re-reads
   // the current word, which keeps the registered ROM output stable.
   always_comb begin
      nxt = pc_f_q + PC_STEP;
      if (!rst_n || (state_q == BOOT)) begin
         nxt = RESET_PC;
      end else if (redirect) begin
         nxt = redirect_pc;
      end else if (stall) begin
         nxt = pc_f_q;
      end
   end

   // A fetch address must be word aligned and inside the ROM; anything past
   // the last word (including the sequential wrap) is illegal.
   assign nxt_legal = (nxt[1:0] == 2'b00) && (nxt[31:ADDR_W+2] == '0);

   // Once faulted the ROM keeps reading the last good word; reset takes
   // precedence so the reset vector is presented while rst_n is low.
   assign imem_addr = (rst_n && (state_q == FAULT)) ? pc_f_q[ADDR_W+1:2]
                                                    : nxt[ADDR_W+1:2];

   assign if_valid = (state_q == RUN);
   assign accept   = if_valid & ~stall & ~redirect;

   // FSM next-state and datapath updates. pc_f only advances on a legal
   // fetch, so after a fault it still names the last word actually read.
   always_comb begin
      state_d       = state_q;
      pc_f_d        = pc_f_q;
      fault_pc_d    = fault_pc_q;
      fetch_count_d = fetch_count_q;

      if (accept && (fetch_count_q != 32'hFFFF_FFFF)) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end

      unique case (state_q)
         BOOT: begin
            pc_f_d  = nxt;
            state_d = RUN;
         end
         RUN: begin
            if (nxt_legal) begin
               pc_f_d = nxt;
            end else begin
               state_d    = FAULT;
               fault_pc_d = nxt;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pc_f_q        <= RESET_PC;
         fault_pc_q    <= 32'h0000_0000;
         fetch_count_q <= 32'h0000_0000;
      end else begin
         state_q       <= state_d;
         pc_f_q        <= pc_f_d;
         fault_pc_q    <= fault_pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign if_instr    = imem_ir;
   assign if_pc       = pc_f_q;
   assign if_pc4      = pc_f_q + PC_STEP;
   assign fault       = (state_q == FAULT);
   assign fault_pc    = fault_pc_q;
   assign fetch_count = fetch_count_q;

endmodule : ifetch

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch
// Directed bench for ifetch with a behavioural registered ROM. Each cycle the
// expected fetch outcome is modelled and pushed to a scoreboard when the
// inputs are driven, then popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_ifetch;

   localparam int ADDR_W = 10;

   logic              clk;
   logic              rst_n;
   logic              stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_ir;
   logic [31:0]       if_instr;
   logic [31:0]       if_pc;
   logic [31:0]       if_pc4;
   logic              if_valid;
   logic              fault;
   logic [31:0]       fault_pc;
   logic [31:0]       fetch_count;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
      logic [31:0] fault_pc;
      logic [31:0] count;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   // Bench-side model of the fetch unit
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_fault;
   logic [31:0] m_fault_pc;
   logic [31:0] m_count;

   ifetch #(
      .RESET_PC (32'h0000_0000),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_ir     (imem_ir),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_pc4      (if_pc4),
      .if_valid    (if_valid),
      .fault       (fault),
      .fault_pc    (fault_pc),
      .fetch_count (fetch_count)
   );

   // ROM contents: two known words at the start, an index-tagged pattern elsewhere
   function automatic logic [31:0] romWord(input logic [ADDR_W-1:0] idx);
      if (idx == 0)      return 32'h2008_0005;
      else if (idx == 1) return 32'h2009_0001;
      else               return 32'hC0DE_0000 | {22'd0, idx};
   endfunction

   // Registered ROM with one-cycle read latency
   always @(posedge clk) begin
      imem_ir <= romWord(imem_addr);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic isLegal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a[31:ADDR_W+2] == '0);
   endfunction

   function automatic exp_t snapshot();
      exp_t e;
      e.valid    = m_valid;
      e.pc       = m_pc;
      e.instr    = romWord(m_pc[ADDR_W+1:2]);
      e.fault    = m_fault;
      e.fault_pc = m_fault_pc;
      e.count    = m_count;
      return e;
   endfunction

   // Pops one scoreboard entry and compares it with the DUT outputs
   task automatic checkOutput(input string tag);
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
         return;
      end
      e = sb.pop_front();
      check32({tag, ".valid"}, {31'd0, if_valid}, {31'd0, e.valid});
      check32({tag, ".fault"}, {31'd0, fault}, {31'd0, e.fault});
      check32({tag, ".fault_pc"}, fault_pc, e.fault_pc);
      check32({tag, ".count"}, fetch_count, e.count);
      if (e.valid) begin
         check32({tag, ".pc"}, if_pc, e.pc);
         check32({tag, ".instr"}, if_instr, e.instr);
         check32({tag, ".pc4"}, if_pc4, e.pc + 32'd4);
      end
   endtask

   // One running cycle: drive inputs, model the outcome, clock, compare
   task automatic applyStimulus(input string tag, input logic st, input logic rd,
                                input logic [31:0] rpc);
      logic [31:0] nxt;
      logic [31:0] exp_addr;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      if (m_fault) begin
         exp_addr = {22'd0, m_pc[ADDR_W+1:2]};
      end else begin
         if (m_valid && !st && !rd && (m_count != 32'hFFFF_FFFF)) m_count++;
         nxt      = rd ? rpc : (st ? m_pc : m_pc + 32'd4);
         exp_addr = {22'd0, nxt[ADDR_W+1:2]};
         if (isLegal(nxt)) begin
            m_pc = nxt;
         end else begin
            m_fault    = 1'b1;
            m_fault_pc = nxt;
            m_valid    = 1'b0;
         end
      end
      sb.push_back(snapshot());
      #1;
      check32({tag, ".imem_addr"}, {22'd0, imem_addr}, exp_addr);
      @(posedge clk);
      #1;
      stall    = 1'b0;
      redirect = 1'b0;
      checkOutput(tag);
   endtask

   // One cycle with rst_n low; everything must be cleared after the edge
   task automatic resetCycle(input string tag);
      rst_n    = 1'b0;
      stall    = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0042;
      m_pc       = 32'h0;
      m_valid    = 1'b0;
      m_fault    = 1'b0;
      m_fault_pc = 32'h0;
      m_count    = 32'h0;
      #1;
      check32({tag, ".imem_addr"}, {22'd0, imem_addr}, 32'h0);
      sb.push_back(snapshot());
      @(posedge clk);
      #1;
      stall    = 1'b0;
      redirect = 1'b0;
      checkOutput(tag);
   endtask

   // First edge with rst_n high: the reset word must appear in the next cycle
   task automatic bootStep(input string tag);
      rst_n    = 1'b1;
      stall    = 1'b0;
      redirect = 1'b0;
      m_pc     = 32'h0;
      m_valid  = 1'b1;
      #1;
      check32({tag, ".boot_valid"}, {31'd0, if_valid}, 32'd0);
      check32({tag, ".imem_addr"}, {22'd0, imem_addr}, 32'h0);
      sb.push_back(snapshot());
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      m_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_fault_pc = 32'h0; m_count = 32'h0;

      @(posedge clk);
      #1;
      resetCycle("reset0");
      resetCycle("reset1");
      bootStep("boot");

      applyStimulus("seq_pc4", 1'b0, 1'b0, 32'h0);
      applyStimulus("seq_pc8", 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus("stall_pc8", 1'b1, 1'b0, 32'h0);
      applyStimulus("resume_pc12", 1'b0, 1'b0, 32'h0);
      applyStimulus("redir_stall", 1'b1, 1'b1, 32'h0000_0040);
      applyStimulus("after_redir", 1'b0, 1'b0, 32'h0);
      applyStimulus("redir_top", 1'b0, 1'b1, 32'h0000_0FF4);
      applyStimulus("seq_ff8", 1'b0, 1'b0, 32'h0);
      applyStimulus("seq_ffc", 1'b0, 1'b0, 32'h0);
      applyStimulus("wrap_fault", 1'b0, 1'b0, 32'h0);
      applyStimulus("fault_hold", 1'b0, 1'b1, 32'h0000_0080);
      applyStimulus("fault_hold2", 1'b0, 1'b0, 32'h0);
      check32("count_at_fault", fetch_count, 32'd7);

      resetCycle("reset_in_fault");
      bootStep("reboot");
      applyStimulus("seq_after_reboot", 1'b0, 1'b0, 32'h0);
      applyStimulus("misaligned", 1'b0, 1'b1, 32'h0000_0042);
      applyStimulus("misaligned_hold", 1'b1, 1'b1, 32'h0000_0100);
      applyStimulus("misaligned_hold2", 1'b0, 1'b0, 32'h0);

      resetCycle("reset_final");
      bootStep("boot_final");
      applyStimulus("seq_final", 1'b0, 1'b0, 32'h0);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ifetch
